// File: rtl/dda_step_generator_pkg.sv
// Shared types and constants for the DDA step generator and its helpers.
package dda_step_generator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DIR_SETUP = 2'd1,
        RUN       = 2'd2,
        DRAIN     = 2'd3
    } state_t;

    localparam int MIN_PULSE_WIDTH = 1;

    localparam int DEF_ACC_WIDTH  = 32;
    localparam int DEF_TICK_WIDTH = 32;
    localparam int DEF_POS_WIDTH  = 32;

    // Clamp a programmed pulse width to the minimum the downstream accepts.
    function automatic logic [7:0] eff_pulse_width(input logic [7:0] w);
        return (w < 8'(MIN_PULSE_WIDTH)) ? 8'(MIN_PULSE_WIDTH) : w;
    endfunction

endpackage

// File: rtl/dda_step_generator_if.sv
// Move-command channel into the DDA step generator.
//
// Handshake: the master holds move_valid and the move_* fields stable until
// a cycle in which move_valid & move_ready are both high; that cycle is the
// transfer. move_ready never depends on move_valid.
import dda_step_generator_pkg::*;

interface dda_step_generator_if #(
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int TICK_WIDTH = DEF_TICK_WIDTH
);
    logic                  move_valid;
    logic                  move_ready;
    logic                  move_dir;
    logic [ACC_WIDTH-1:0]  move_increment;
    logic [TICK_WIDTH-1:0] move_ticks;

    modport master (
        output move_valid, move_dir, move_increment, move_ticks,
        input  move_ready
    );

    modport slave (
        input  move_valid, move_dir, move_increment, move_ticks,
        output move_ready
    );
endinterface

// File: rtl/dda_step_generator_step_pulse_stretcher.sv
// Registered pulse stretcher: a trigger while idle produces a high output
// for max(width,1) cycles starting the next cycle. Triggers while the pulse
// is high are ignored (the caller decides what that means). Abort truncates.
// Also used wherever a minimum-width strobe is needed.
import dda_step_generator_pkg::*;

module step_pulse_stretcher (
    input  logic       clk,
    input  logic       resetn,
    input  logic       trigger,
    input  logic [7:0] width,
    input  logic       abort,
    output logic       step,
    output logic       active
);
    logic       step_q;
    logic [7:0] cnt_q;

    // Pulse timer: cnt_q holds the number of high cycles remaining after this one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            step_q <= 1'b0;
            cnt_q  <= 8'd0;
        end else if (abort) begin
            step_q <= 1'b0;
            cnt_q  <= 8'd0;
        end else if (step_q) begin
            if (cnt_q == 8'd0) begin
                step_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 8'd1;
            end
        end else if (trigger) begin
            step_q <= 1'b1;
            cnt_q  <= eff_pulse_width(width) - 8'd1;
        end
    end

    assign step   = step_q;
    assign active = step_q;
endmodule

// File: rtl/dda_step_generator.sv
// DDA step generator: accepts queued moves, runs a phase accumulator once per
// clk while enabled, and emits registered step/dir to the microstepper.
// Optional macro DDA_POSITION_EN builds the signed position counter;
// without it, position is tied to zero.
import dda_step_generator_pkg::*;

module dda_step_generator #(
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int TICK_WIDTH = DEF_TICK_WIDTH,
    parameter int POS_WIDTH  = DEF_POS_WIDTH
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic                 abort,
    dda_step_generator_if.slave  move,
    input  logic [7:0]           config_step_pulse_width,
    input  logic [7:0]           config_dir_setup,
    output logic                 step,
    output logic                 dir,
    output logic                 busy,
    output logic                 move_done,
    output logic                 step_overrun,
    output logic [POS_WIDTH-1:0] position,
    output state_t               dbg_state
);
    state_t                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, inc_q;
    logic [TICK_WIDTH-1:0] ticks_left_q;
    logic [7:0]            setup_cnt_q;
    logic                  dir_q, done_d, move_done_q, overrun_q;
    logic                  accept, run_tick, carry, fire, pulse_active;
    logic [ACC_WIDTH:0]    sum;

    assign move.move_ready = resetn & (state_q == IDLE) & enable & ~abort;
    assign accept          = move.move_valid & move.move_ready;
    // Abort outranks accumulation, so a same-cycle carry is discarded.
    assign run_tick        = (state_q == RUN) & enable & ~abort;
    assign sum             = {1'b0, acc_q} + {1'b0, inc_q};
    assign carry           = run_tick & sum[ACC_WIDTH];
    assign fire            = carry & ~pulse_active;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state and completion strobe.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (move.move_ticks == '0)     done_d  = 1'b1;
                    else if (move.move_dir != dir_q) state_d = DIR_SETUP;
                    else                             state_d = RUN;
                end
            end
            DIR_SETUP: if (setup_cnt_q == 8'd0) state_d = RUN;
            RUN:       if (run_tick && ticks_left_q == TICK_WIDTH'(1)) state_d = DRAIN;
            DRAIN: begin
                if (!pulse_active) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default:   state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end
    end

    // Move latch, direction, setup countdown and accumulator. The accumulator
    // carries its fractional phase across moves; only reset/abort clear it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q        <= '0;
            inc_q        <= '0;
            ticks_left_q <= '0;
            setup_cnt_q  <= 8'd0;
            dir_q        <= 1'b0;
        end else if (abort) begin
            acc_q <= '0;
        end else begin
            if (accept) begin
                inc_q        <= move.move_increment;
                ticks_left_q <= move.move_ticks;
                setup_cnt_q  <= config_dir_setup;
                if (move.move_ticks != '0) dir_q <= move.move_dir;
            end
            if (state_q == DIR_SETUP && setup_cnt_q != 8'd0) begin
                setup_cnt_q <= setup_cnt_q - 8'd1;
            end
            if (run_tick) begin
                acc_q        <= sum[ACC_WIDTH-1:0];
                ticks_left_q <= ticks_left_q - TICK_WIDTH'(1);
            end
        end
    end

    // Completion pulse and sticky overrun flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            move_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            move_done_q <= done_d;
            if (carry && pulse_active) overrun_q <= 1'b1;
        end
    end

    step_pulse_stretcher u_stretcher (
        .clk     (clk),
        .resetn  (resetn),
        .trigger (fire),
        .width   (config_step_pulse_width),
        .abort   (abort),
        .step    (step),
        .active  (pulse_active)
    );

`ifdef DDA_POSITION_EN
    logic [POS_WIDTH-1:0] position_q;

    // Position moves in the same cycle the step output rises.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)   position_q <= '0;
        else if (fire) position_q <= dir_q ? position_q + POS_WIDTH'(1)
                                           : position_q - POS_WIDTH'(1);
    end
    assign position = position_q;
`else
    assign position = '0;
`endif

    assign dir          = dir_q;
    assign busy         = (state_q != IDLE);
    assign move_done    = move_done_q;
    assign step_overrun = overrun_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_dda_step_generator.sv
// Directed bench for dda_step_generator. Cycle numbers: a value driven at the
// negedge where cyc==n belongs to cycle n; registered effects of cycle n are
// observed at the negedge where cyc==n+1.
import dda_step_generator_pkg::*;

module tb_dda_step_generator;
  logic        clk = 1'b0;
  logic        resetn, enable, abort;
  logic [7:0]  cfg_width, cfg_setup;
  logic        step, dir, busy, move_done, step_overrun;
  logic [31:0] position;
  state_t      dbg_state;

  dda_step_generator_if mv ();

  dda_step_generator dut (
    .clk                     (clk),
    .resetn                  (resetn),
    .enable                  (enable),
    .abort                   (abort),
    .move                    (mv),
    .config_step_pulse_width (cfg_width),
    .config_dir_setup        (cfg_setup),
    .step                    (step),
    .dir                     (dir),
    .busy                    (busy),
    .move_done               (move_done),
    .step_overrun            (step_overrun),
    .position                (position),
    .dbg_state               (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  int   rise_q[$];
  int   fall_q[$];
  int   done_q[$];
  logic step_prev = 1'b0;

  always @(negedge clk) begin
    if (step && !step_prev) rise_q.push_back(cyc);
    if (!step && step_prev) fall_q.push_back(cyc);
    if (move_done) done_q.push_back(cyc);
    step_prev = step;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Compare step rise cycles since index base against exp_q, then clear exp_q.
  task automatic check_rises(input string tag, input int base);
    check_eq({tag, "_rise_count"}, rise_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < rise_q.size(); i++)
      check_eq({tag, "_rise_cyc"}, rise_q[base + i], exp_q[i]);
    exp_q.delete();
  endtask

  function automatic int last_done();
    return (done_q.size() == 0) ? -1 : done_q[done_q.size() - 1];
  endfunction

  function automatic int last_fall();
    return (fall_q.size() == 0) ? -1 : fall_q[fall_q.size() - 1];
  endfunction

  function automatic logic [31:0] pos_exp(input int p);
    logic [31:0] r;
    r = p;
`ifndef DDA_POSITION_EN
    r = '0;
`endif
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  int n_cyc;

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    abort  = 1'b0;
    enable = 1'b1;
    mv.move_valid = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_move(input logic d, input logic [31:0] inc, input logic [31:0] t);
    int i;
    i = 0;
    @(negedge clk);
    while (!move_ready_now() && i < 50) begin
      @(negedge clk);
      i++;
    end
    check_eq("accept_ready", mv.move_ready, 1'b1);
    mv.move_valid     = 1'b1;
    mv.move_dir       = d;
    mv.move_increment = inc;
    mv.move_ticks     = t;
    n_cyc = cyc;
    @(negedge clk);
    mv.move_valid = 1'b0;
  endtask

  function automatic logic move_ready_now();
    return mv.move_ready;
  endfunction

  // ---------------- stimulus ----------------
  int base;
  int dbase;

  initial begin
    resetn = 1'b0; enable = 1'b1; abort = 1'b0;
    cfg_width = 8'd1; cfg_setup = 8'd0;
    mv.move_valid = 1'b0; mv.move_dir = 1'b0;
    mv.move_increment = '0; mv.move_ticks = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_ready", mv.move_ready, 1'b0);
    check_eq("rst_step", step, 1'b0);
    check_eq("rst_dir", dir, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", move_done, 1'b0);
    check_eq("rst_overrun", step_overrun, 1'b0);
    check_eq("rst_position", position, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    #1;
    check_eq("post_rst_ready", mv.move_ready, 1'b1);

    // Test 4: zero-tick move
    base = rise_q.size();
    send_move(1'b0, 32'h1234_5678, 32'd0);
    wait_cyc(n_cyc + 1);
    check_eq("t4_done_n1", move_done, 1'b1);
    check_eq("t4_busy", busy, 1'b0);
    wait_cyc(n_cyc + 2);
    check_eq("t4_done_one_cycle", move_done, 1'b0);
    wait_cyc(n_cyc + 6);
    check_rises("t4", base);

    // Seed accumulator phase to 3 (single tick, no carry)
    send_move(1'b0, 32'd3, 32'd1);
    wait_cyc(n_cyc + 8);

    // Test 2: dir change with setup of 5, increment all-ones
    cfg_setup = 8'd5; cfg_width = 8'd1;
    base = rise_q.size();
    check_eq("t2_dir_before", dir, 1'b0);
    send_move(1'b1, 32'hFFFF_FFFF, 32'd3);
    wait_cyc(n_cyc + 1);
    check_eq("t2_dir_n1", dir, 1'b1);
    check_eq("t2_state_setup", dbg_state, DIR_SETUP);
    check_eq("t2_busy", busy, 1'b1);
    wait_cyc(n_cyc + 7);
    check_eq("t2_state_run_n7", dbg_state, RUN);
    check_eq("t2_step_n7", step, 1'b0);
    wait_cyc(n_cyc + 8);
    check_eq("t2_step_n8", step, 1'b1);
    wait_cyc(n_cyc + 20);
    exp_q.push_back(n_cyc + 8);
    exp_q.push_back(n_cyc + 10);
    check_rises("t2", base);
    check_eq("t2_overrun", step_overrun, 1'b1);
    check_eq("t2_done_cyc", last_done(), n_cyc + 12);
    check_eq("t2_position", position, pos_exp(2));

    // Test 1: half-scale increment, dir unchanged, width 1
    cfg_width = 8'd1;
    base = rise_q.size();
    send_move(1'b1, 32'h8000_0000, 32'd8);
    wait_cyc(n_cyc + 20);
    exp_q.push_back(n_cyc + 3);
    exp_q.push_back(n_cyc + 5);
    exp_q.push_back(n_cyc + 7);
    exp_q.push_back(n_cyc + 9);
    check_rises("t1", base);
    check_eq("t1_last_fall", last_fall(), n_cyc + 10);
    check_eq("t1_done_cyc", last_done(), n_cyc + 11);
    check_eq("t1_position", position, pos_exp(6));
    check_eq("t1_busy_end", busy, 1'b0);

    // Test 3: width 3 forces overruns on every other carry
    do_reset();
    check_eq("t3_overrun_clr", step_overrun, 1'b0);
    check_eq("t3_position_clr", position, 32'd0);
    cfg_width = 8'd3;
    base = rise_q.size();
    send_move(1'b0, 32'h8000_0000, 32'd8);
    wait_cyc(n_cyc + 4);
    check_eq("t3_overrun_n4", step_overrun, 1'b0);
    wait_cyc(n_cyc + 5);
    check_eq("t3_overrun_n5", step_overrun, 1'b1);
    check_eq("t3_step_n5", step, 1'b1);
    wait_cyc(n_cyc + 6);
    check_eq("t3_step_n6", step, 1'b0);
    wait_cyc(n_cyc + 20);
    exp_q.push_back(n_cyc + 3);
    exp_q.push_back(n_cyc + 7);
    check_rises("t3", base);
    check_eq("t3_done_cyc", last_done(), n_cyc + 11);
    check_eq("t3_position", position, pos_exp(-2));

    // Test 5: abort while step is high (acc left at nonzero phase)
    base  = rise_q.size();
    dbase = done_q.size();
    send_move(1'b0, 32'h6000_0000, 32'd8);
    wait_cyc(n_cyc + 5);
    check_eq("t5_step_before_abort", step, 1'b1);
    abort = 1'b1;
    wait_cyc(n_cyc + 6);
    check_eq("t5_step_cut", step, 1'b0);
    check_eq("t5_busy", busy, 1'b0);
    check_eq("t5_ready_in_abort", mv.move_ready, 1'b0);
    mv.move_valid = 1'b1; mv.move_dir = 1'b1;
    mv.move_increment = 32'h4000_0000; mv.move_ticks = 32'd4;
    wait_cyc(n_cyc + 7);
    check_eq("t5_no_accept", busy, 1'b0);
    check_eq("t5_dir_kept", dir, 1'b0);
    mv.move_valid = 1'b0;
    abort = 1'b0;
    #1;
    check_eq("t5_ready_back", mv.move_ready, 1'b1);
    wait_cyc(n_cyc + 16);
    check_eq("t5_no_done", done_q.size() - dbase, 0);
    exp_q.push_back(n_cyc + 4);
    check_rises("t5", base);
    check_eq("t5_position", position, pos_exp(-3));

    // Test 6: enable low for cycles n+3..n+12; width 0 behaves as 1
    cfg_width = 8'd0;
    base = rise_q.size();
    send_move(1'b0, 32'h8000_0000, 32'd8);
    wait_cyc(n_cyc + 3);
    enable = 1'b0;
    check_eq("t6_pulse_in_flight", step, 1'b1);
    wait_cyc(n_cyc + 8);
    check_eq("t6_state_paused", dbg_state, RUN);
    check_eq("t6_paused_rises", rise_q.size() - base, 1);
    wait_cyc(n_cyc + 13);
    enable = 1'b1;
    wait_cyc(n_cyc + 30);
    exp_q.push_back(n_cyc + 3);
    exp_q.push_back(n_cyc + 15);
    exp_q.push_back(n_cyc + 17);
    exp_q.push_back(n_cyc + 19);
    check_rises("t6", base);
    check_eq("t6_done_cyc", last_done(), n_cyc + 21);
    check_eq("t6_position", position, pos_exp(-7));

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
